// File: rtl/nco_pkg.sv
// nco_pkg - shared definitions for the numerically controlled phase generator.
//
// Contents:
//   PHASE_W      width of the phase word handed to the cosine lookup
//   nco_state_e  controller states (SWEEP is only reachable when the
//                NCO_SWEEP_EN macro is defined)
//   ADDR_*       configuration register addresses on cfg_addr
package nco_pkg;

  localparam int PHASE_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } nco_state_e;

  localparam logic [1:0] ADDR_FREQ         = 2'd0;
  localparam logic [1:0] ADDR_PHASE_OFS    = 2'd1;
  localparam logic [1:0] ADDR_SWEEP_STEP   = 2'd2;
  localparam logic [1:0] ADDR_SWEEP_TARGET = 2'd3;

endpackage

// File: rtl/nco_sweep.sv
// nco_sweep - combinational step/clamp logic of the linear frequency sweep.
//
// Computes the frequency word for the next sample while a sweep is active and
// flags when the sweep has finished.
//
// Ports:
//   freq      in   ACC_W   current frequency word
//   step      in   STEP_W  signed per-tick frequency increment
//   target    in   ACC_W   frequency the sweep is heading for
//   freqNext  out  ACC_W   frequency to use from the next tick on
//   hit       out  1       sweep reached/crossed target or left the legal range
module nco_sweep #(
  parameter int ACC_W  = 24,
  parameter int STEP_W = 16
) (
  input  logic [ACC_W-1:0]  freq,
  input  logic [STEP_W-1:0] step,
  input  logic [ACC_W-1:0]  target,
  output logic [ACC_W-1:0]  freqNext,
  output logic              hit
);

  // Two guard bits: one for carry past 2^ACC_W, one for the sign, so that both
  // overflow and underflow of the unsigned frequency word are visible.
  localparam int EXT_W = ACC_W + 2;

  logic signed [EXT_W-1:0] freqExt;
  logic signed [EXT_W-1:0] stepExt;
  logic signed [EXT_W-1:0] targetExt;
  logic signed [EXT_W-1:0] sumExt;
  logic                    outOfRange;
  logic                    crossed;

  assign freqExt   = $signed({2'b00, freq});
  assign stepExt   = $signed({{(EXT_W-STEP_W){step[STEP_W-1]}}, step});
  assign targetExt = $signed({2'b00, target});
  assign sumExt    = freqExt + stepExt;

  // Negative sum sets the sign bit; a sum of 2^ACC_W or more sets the carry bit.
  assign outOfRange = sumExt[EXT_W-1] | sumExt[ACC_W];

  // The direction of travel is the sign of the step, so "reached" means
  // at-or-above the target when rising and at-or-below it when falling.
  assign crossed = step[STEP_W-1] ? (sumExt <= targetExt) : (sumExt >= targetExt);

  assign hit      = outOfRange | crossed;
  assign freqNext = hit ? target : sumExt[ACC_W-1:0];

endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen - phase accumulator NCO feeding a 10-bit-phase cosine lookup.
//
// On every accepted sample_tick the accumulator advances by FREQ and the top
// PHASE_W bits of the new accumulator, plus PHASE_OFS, are registered onto
// phase_out with a one-cycle phase_valid pulse. wrap flags the accumulator
// carry-out on that same update.
//
// Optional feature: define NCO_SWEEP_EN to build the linear frequency sweep
// (SWEEP state, SWEEP_STEP/SWEEP_TARGET registers, sweep_done). Without it,
// writes to addresses 2 and 3 are ignored and sweep_done is tied low.
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      level; low forces IDLE and clears acc/phase_out
//   sample_tick  in   1      one-cycle strobe per output sample
//   cfg_wr       in   1      register write strobe
//   cfg_addr     in   2      0=FREQ 1=PHASE_OFS 2=SWEEP_STEP 3=SWEEP_TARGET
//   cfg_data     in   ACC_W  write data, narrower registers take the LSBs
//   phase_out    out  10     phase word to the cosine lookup
//   phase_valid  out  1      pulse when phase_out updates
//   wrap         out  1      pulse on accumulator carry-out
//   sweep_done   out  1      pulse when a sweep reaches its target
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int STEP_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_tick,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [ACC_W-1:0]   cfg_data,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               wrap,
  output logic               sweep_done
);

  // The phase word is sliced from the top of the accumulator and the sweep
  // step is sign-extended into it, so both must fit.
  if (ACC_W < 12 || STEP_W < 2 || STEP_W > ACC_W) begin : g_bad_params
    $error("nco_phase_gen: need ACC_W >= 12 and 2 <= STEP_W <= ACC_W");
  end

  nco_state_e          state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    freq;
  logic [PHASE_W-1:0]  phaseOfs;
  logic [ACC_W:0]      accSum;

  // Extra top bit of the sum is the carry that drives wrap.
  assign accSum = {1'b0, acc} + {1'b0, freq};

`ifdef NCO_SWEEP_EN
  logic [STEP_W-1:0] sweepStep;
  logic [ACC_W-1:0]  sweepTarget;
  logic [ACC_W-1:0]  sweepFreq;
  logic              sweepHit;
  logic              sweepDoneQ;

  nco_sweep #(
    .ACC_W  (ACC_W),
    .STEP_W (STEP_W)
  ) u_sweep (
    .freq     (freq),
    .step     (sweepStep),
    .target   (sweepTarget),
    .freqNext (sweepFreq),
    .hit      (sweepHit)
  );

  assign sweep_done = sweepDoneQ;
`else
  assign sweep_done = 1'b0;
`endif

  // Controller, accumulator and configuration registers in one block. The
  // tick update is written first and the register write afterwards, so a
  // write landing in the same cycle as a tick lets the tick see the old values
  // while the written value (and any state change it causes) wins at the edge.
  // A FREQ write or a zero-step target write during a sweep ends it without
  // sweep_done, even if this cycle's tick would have completed it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      freq        <= '0;
      phaseOfs    <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
`ifdef NCO_SWEEP_EN
      sweepStep   <= '0;
      sweepTarget <= '0;
      sweepDoneQ  <= 1'b0;
`endif
    end else begin
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
`ifdef NCO_SWEEP_EN
      sweepDoneQ  <= 1'b0;
`endif

      if (!enable) begin
        state     <= IDLE;
        acc       <= '0;
        phase_out <= '0;
      end else if (state == IDLE) begin
        state <= RUN;
      end else if (sample_tick) begin
        acc         <= accSum[ACC_W-1:0];
        wrap        <= accSum[ACC_W];
        phase_out   <= accSum[ACC_W-1 -: PHASE_W] + phaseOfs;
        phase_valid <= 1'b1;
`ifdef NCO_SWEEP_EN
        if (state == SWEEP) begin
          freq <= sweepFreq;
          if (sweepHit) begin
            state      <= RUN;
            sweepDoneQ <= 1'b1;
          end
        end
`endif
      end

      if (cfg_wr) begin
        case (cfg_addr)
          ADDR_FREQ: begin
            freq <= cfg_data;
`ifdef NCO_SWEEP_EN
            if (enable && state == SWEEP) begin
              state      <= RUN;
              sweepDoneQ <= 1'b0;
            end
`endif
          end
          ADDR_PHASE_OFS: phaseOfs <= cfg_data[PHASE_W-1:0];
`ifdef NCO_SWEEP_EN
          ADDR_SWEEP_STEP: sweepStep <= cfg_data[STEP_W-1:0];
          ADDR_SWEEP_TARGET: begin
            sweepTarget <= cfg_data;
            if (sweepStep == '0) begin
              freq <= cfg_data;
              if (enable && state == SWEEP) begin
                state      <= RUN;
                sweepDoneQ <= 1'b0;
              end
            end else if (enable && state != IDLE) begin
              state <= SWEEP;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen - self-checking bench for nco_phase_gen (ACC_W=24, STEP_W=16).
//
// Directed scenarios use hand-derived constants; the randomized scenario is
// checked against a behavioural model of the NCO built from integer
// arithmetic. Sweep-specific expectations follow the NCO_SWEEP_EN macro.
module tb_nco_phase_gen;

  localparam int    ACC_W   = 24;
  localparam int    STEP_W  = 16;
  localparam longint ACC_MOD = 64'h100_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sample_tick = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [1:0]        cfg_addr = 2'd0;
  logic [ACC_W-1:0]  cfg_data = '0;
  logic [9:0]        phase_out;
  logic              phase_valid;
  logic              wrap;
  logic              sweep_done;

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model state: running/sweeping flags and plain integers.
  longint mAcc = 0, mFreq = 0, mOfs = 0, mStep = 0, mTgt = 0;
  bit     mRun = 0, mSweep = 0;
  longint ePhase = 0;
  bit     eValid = 0, eWrap = 0, eDone = 0;

  nco_phase_gen #(
    .ACC_W  (ACC_W),
    .STEP_W (STEP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_tick (sample_tick),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  // Advances the behavioural model by one clock given that cycle's inputs.
  task automatic modelStep(input logic r, input logic en, input logic tk,
                           input logic wr, input logic [1:0] a,
                           input logic [23:0] d);
    bit wasRun, wasSweep;
    longint sum, nf;
    if (r) begin
      mAcc = 0; mFreq = 0; mOfs = 0; mStep = 0; mTgt = 0;
      mRun = 0; mSweep = 0; ePhase = 0; eValid = 0; eWrap = 0; eDone = 0;
      return;
    end
    wasRun = mRun;
    wasSweep = mSweep;
    eValid = 0; eWrap = 0; eDone = 0;
    if (!en) begin
      mRun = 0; mSweep = 0; mAcc = 0; ePhase = 0;
    end else if (!wasRun) begin
      mRun = 1;
    end else if (tk) begin
      sum = mAcc + mFreq;
      eWrap = (sum >= ACC_MOD);
      mAcc = sum % ACC_MOD;
      ePhase = ((mAcc / 16384) + mOfs) % 1024;
      eValid = 1;
`ifdef NCO_SWEEP_EN
      if (wasSweep) begin
        nf = mFreq + mStep;
        if (nf < 0 || nf >= ACC_MOD || (mStep >= 0 ? nf >= mTgt : nf <= mTgt)) begin
          mFreq = mTgt; mSweep = 0; eDone = 1;
        end else begin
          mFreq = nf;
        end
      end
`endif
    end
    if (wr) begin
      case (a)
        2'd0: begin
          mFreq = longint'(d);
          if (en && wasSweep) begin mSweep = 0; eDone = 0; end
        end
        2'd1: mOfs = longint'(d[9:0]);
`ifdef NCO_SWEEP_EN
        2'd2: mStep = longint'($signed(d[15:0]));
        2'd3: begin
          mTgt = longint'(d);
          if (mStep == 0) begin
            mFreq = longint'(d);
            if (en && wasSweep) begin mSweep = 0; eDone = 0; end
          end else if (en && wasRun) begin
            mSweep = 1;
          end
        end
`endif
        default: ;
      endcase
    end
  endtask

  // Drives one cycle of inputs, updates the model, and returns #1 after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic tk,
                               input logic wr, input logic [1:0] a,
                               input logic [23:0] d);
    reset = r; enable = en; sample_tick = tk; cfg_wr = wr; cfg_addr = a; cfg_data = d;
    modelStep(r, en, tk, wr, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, 2'd0, 24'h0);
    applyStimulus(1, 0, 0, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== 10'h0) $display("[TB] FAIL reset_phase: got %0h expected 0", phase_out);
    else passCount++;
    checkCount++;
    if (phase_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", phase_valid);
    else passCount++;
    checkCount++;
    if (wrap !== 1'b0) $display("[TB] FAIL reset_wrap: got %0b expected 0", wrap);
    else passCount++;
    checkCount++;
    if (sweep_done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", sweep_done);
    else passCount++;
  endtask

  task automatic test_count();
    logic [9:0] expPh;
    applyStimulus(0, 1, 0, 1, 2'd0, 24'h004000);
    for (int k = 1; k <= 1024; k++) begin
      applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
      expPh = 10'(k % 1024);
      checkCount++;
      if (phase_out !== expPh || phase_valid !== 1'b1)
        $display("[TB] FAIL count_phase[%0d]: got %0h/%0b expected %0h/1", k, phase_out, phase_valid, expPh);
      else passCount++;
      checkCount++;
      if (wrap !== (k == 1024))
        $display("[TB] FAIL count_wrap[%0d]: got %0b expected %0b", k, wrap, (k == 1024));
      else passCount++;
    end
  endtask

  task automatic test_offset();
    logic [9:0] expPh;
    applyStimulus(0, 1, 0, 1, 2'd1, 24'h000100);
    applyStimulus(0, 0, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== 10'h0 || phase_valid !== 1'b0)
      $display("[TB] FAIL disable_clear: got %0h/%0b expected 0/0", phase_out, phase_valid);
    else passCount++;
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_valid !== 1'b0)
      $display("[TB] FAIL idle_tick_ignored: got valid %0b expected 0", phase_valid);
    else passCount++;
    for (int k = 1; k <= 'h300; k++) begin
      applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
      expPh = 10'((k + 'h100) % 1024);
      if (k == 1 || k >= 'h2FF) begin
        checkCount++;
        if (phase_out !== expPh)
          $display("[TB] FAIL offset_phase[%0d]: got %0h expected %0h", k, phase_out, expPh);
        else passCount++;
      end
    end
  endtask

  task automatic test_write_collision();
    logic [9:0] expPh [3] = '{10'd1, 10'd2, 10'd4};
    applyStimulus(0, 1, 0, 1, 2'd1, 24'h0);
    applyStimulus(0, 0, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== expPh[0]) $display("[TB] FAIL collide_pre: got %0h expected %0h", phase_out, expPh[0]);
    else passCount++;
    applyStimulus(0, 1, 1, 1, 2'd0, 24'h008000);
    checkCount++;
    if (phase_out !== expPh[1]) $display("[TB] FAIL collide_same: got %0h expected %0h", phase_out, expPh[1]);
    else passCount++;
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== expPh[2]) $display("[TB] FAIL collide_next: got %0h expected %0h", phase_out, expPh[2]);
    else passCount++;
  endtask

`ifdef NCO_SWEEP_EN
  task automatic test_sweep();
    applyStimulus(0, 0, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 0, 1, 2'd0, 24'h001000);
    applyStimulus(0, 1, 0, 1, 2'd2, 24'h000800);
    applyStimulus(0, 1, 0, 1, 2'd3, 24'h002400);
    for (int t = 1; t <= 67; t++) begin
      applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
      if (t <= 5) begin
        checkCount++;
        if (sweep_done !== (t == 3))
          $display("[TB] FAIL sweep_done[%0d]: got %0b expected %0b", t, sweep_done, (t == 3));
        else passCount++;
      end
    end
    checkCount++;
    if (phase_out !== 10'h025)
      $display("[TB] FAIL sweep_clamped_freq: got %0h expected 25", phase_out);
    else passCount++;
  endtask
`endif

  task automatic test_enable_drop();
    logic [9:0] exp1, exp2;
`ifdef NCO_SWEEP_EN
    exp1 = 10'h051; exp2 = 10'h092;
`else
    exp1 = 10'h050; exp2 = 10'h090;
`endif
    applyStimulus(0, 1, 0, 1, 2'd1, 24'h000010);
    applyStimulus(0, 0, 0, 1, 2'd0, 24'h100000);
    applyStimulus(0, 1, 0, 1, 2'd2, 24'h004000);
    applyStimulus(0, 1, 0, 1, 2'd3, 24'h200000);
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    applyStimulus(0, 0, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== 10'h0 || phase_valid !== 1'b0)
      $display("[TB] FAIL drop_clear: got %0h/%0b expected 0/0", phase_out, phase_valid);
    else passCount++;
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_valid !== 1'b0) $display("[TB] FAIL reenable_idle: got valid %0b expected 0", phase_valid);
    else passCount++;
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== exp1 || phase_valid !== 1'b1)
      $display("[TB] FAIL reenable_first: got %0h/%0b expected %0h/1", phase_out, phase_valid, exp1);
    else passCount++;
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== exp2 || sweep_done !== 1'b0)
      $display("[TB] FAIL sweep_abandoned: got %0h/%0b expected %0h/0", phase_out, sweep_done, exp2);
    else passCount++;
  endtask

  task automatic test_target_write();
    logic [9:0] expPh;
`ifdef NCO_SWEEP_EN
    expPh = 10'h012;
`else
    expPh = 10'h050;
`endif
    applyStimulus(0, 1, 0, 1, 2'd2, 24'h000000);
    applyStimulus(0, 1, 0, 1, 2'd3, 24'h008000);
    checkCount++;
    if (sweep_done !== 1'b0) $display("[TB] FAIL zero_step_done: got %0b expected 0", sweep_done);
    else passCount++;
    applyStimulus(0, 0, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== expPh) $display("[TB] FAIL target_write_freq: got %0h expected %0h", phase_out, expPh);
    else passCount++;
  endtask

  task automatic test_random();
    logic       r, en, tk, wr;
    logic [1:0] a;
    logic [23:0] d;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 19) != 0);
      tk = ($urandom_range(0, 9) < 7);
      wr = ($urandom_range(0, 9) < 2);
      a  = 2'($urandom_range(0, 3));
      d  = 24'($urandom);
      if (a == 2'd2) d = 24'($urandom_range(0, 16'hFFFF));
      applyStimulus(r, en, tk, wr, a, d);
      checkCount++;
      if (phase_out !== 10'(ePhase)) $display("[TB] FAIL rand_phase[%0d]: got %0h expected %0h", i, phase_out, 10'(ePhase));
      else passCount++;
      checkCount++;
      if (phase_valid !== eValid) $display("[TB] FAIL rand_valid[%0d]: got %0b expected %0b", i, phase_valid, eValid);
      else passCount++;
      checkCount++;
      if (wrap !== eWrap) $display("[TB] FAIL rand_wrap[%0d]: got %0b expected %0b", i, wrap, eWrap);
      else passCount++;
      checkCount++;
      if (sweep_done !== eDone) $display("[TB] FAIL rand_done[%0d]: got %0b expected %0b", i, sweep_done, eDone);
      else passCount++;
    end
  endtask

  task automatic test_reset_collision();
    applyStimulus(0, 1, 0, 1, 2'd0, 24'h004000);
    applyStimulus(0, 1, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    applyStimulus(1, 1, 1, 1, 2'd1, 24'h000155);
    checkCount++;
    if (phase_out !== 10'h0 || phase_valid !== 1'b0 || wrap !== 1'b0 || sweep_done !== 1'b0)
      $display("[TB] FAIL reset_collide_outputs: got %0h/%0b/%0b/%0b expected 0/0/0/0",
               phase_out, phase_valid, wrap, sweep_done);
    else passCount++;
    applyStimulus(0, 1, 0, 0, 2'd0, 24'h0);
    applyStimulus(0, 1, 1, 0, 2'd0, 24'h0);
    checkCount++;
    if (phase_out !== 10'h0 || phase_valid !== 1'b1)
      $display("[TB] FAIL reset_discards_write: got %0h/%0b expected 0/1", phase_out, phase_valid);
    else passCount++;
  endtask

  // Scenarios run in order; each leaves the model in step with the DUT.
  initial begin
    test_reset();
    test_count();
    test_offset();
    test_write_collision();
`ifdef NCO_SWEEP_EN
    test_sweep();
`endif
    test_enable_drop();
    test_target_write();
    test_random();
    test_reset_collision();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
